// File: rtl/mempool_dma_arbiter.sv
// Round-robin arbiter sharing the cluster DMA request channel among several frontends.
// Holds the grant until the DMA reports completion, then pulses a per-requester done.
module mempool_dma_arbiter #(
    parameter int unsigned NumRequesters = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned LenWidth      = 32,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumRequesters*AddrWidth-1:0]   req_src_i,
    input  logic [NumRequesters*AddrWidth-1:0]   req_dst_i,
    input  logic [NumRequesters*LenWidth-1:0]    req_num_bytes_i,
    input  logic [NumRequesters-1:0]             req_valid_i,
    output logic [NumRequesters-1:0]             req_ready_o,
    output logic [NumRequesters-1:0]             req_done_o,
    output logic [AddrWidth-1:0]                 dma_src_o,
    output logic [AddrWidth-1:0]                 dma_dst_o,
    output logic [LenWidth-1:0]                  dma_num_bytes_o,
    output logic                                 dma_valid_o,
    input  logic                                 dma_ready_i,
    input  logic                                 dma_trans_complete_i,
    output logic                                 busy_o,
    output logic [$clog2(NumRequesters)-1:0]     owner_o,
    output logic                                 error_o,
    input  logic                                 clear_error_i
);

    localparam int unsigned IdxWidth = $clog2(NumRequesters);
    localparam int unsigned CntWidth = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                state_q;
    logic [IdxWidth-1:0]   rr_q, owner_q, winner;
    logic [CntWidth-1:0]   cnt_q;
    logic                  error_q;
    logic [AddrWidth-1:0]  src_q, dst_q, src_sel, dst_sel;
    logic [LenWidth-1:0]   len_q, len_sel;
    logic                  found;
    logic                  timeout_hit;
    logic [31:0]           idx;

    // First valid requester scanning upwards from the round-robin pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NumRequesters; k++) begin
            idx = (32'(rr_q) + k) % NumRequesters;
            if (!found && req_valid_i[idx[IdxWidth-1:0]]) begin
                found  = 1'b1;
                winner = idx[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        src_sel = '0;
        dst_sel = '0;
        len_sel = '0;
        for (int unsigned k = 0; k < NumRequesters; k++) begin
            if (IdxWidth'(k) == winner) begin
                src_sel = req_src_i[k*AddrWidth +: AddrWidth];
                dst_sel = req_dst_i[k*AddrWidth +: AddrWidth];
                len_sel = req_num_bytes_i[k*LenWidth +: LenWidth];
            end
        end
    end

    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            // Clear first so a same-cycle timeout below overrides it.
            if (clear_error_i) error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        owner_q <= winner;
                        src_q   <= src_sel;
                        dst_q   <= dst_sel;
                        len_q   <= len_sel;
                        rr_q    <= (winner == IdxWidth'(NumRequesters - 1)) ? '0 : winner + 1'b1;
                        state_q <= (len_sel == '0) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    if (dma_ready_i) begin
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != {CntWidth{1'b1}}) cnt_q <= cnt_q + 1'b1;
                    if (dma_trans_complete_i) begin
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        req_done_o  = '0;
        if (state_q == StIdle && found && !rst_i) req_ready_o[winner] = 1'b1;
        if (state_q == StDone) req_done_o[owner_q] = 1'b1;
    end

    assign dma_valid_o     = (state_q == StIssue);
    assign busy_o          = (state_q != StIdle);
    assign dma_src_o       = src_q;
    assign dma_dst_o       = dst_q;
    assign dma_num_bytes_o = len_q;
    assign owner_o         = owner_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_mempool_dma_arbiter.sv
// Randomised bench for mempool_dma_arbiter against a transaction-level reference model.
// The model tracks the round-robin pointer and sticky error; timing follows the block's latency rules.
module tb_mempool_dma_arbiter;

    localparam int N = 4;
    localparam int A = 32;
    localparam int L = 32;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [N*A-1:0] req_src_i = '0;
    logic [N*A-1:0] req_dst_i = '0;
    logic [N*L-1:0] req_num_bytes_i = '0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_ready_o, req_done_o;
    logic [A-1:0]   dma_src_o, dma_dst_o;
    logic [L-1:0]   dma_num_bytes_o;
    logic           dma_valid_o, busy_o, error_o;
    logic           dma_ready_i = 1'b0;
    logic           dma_trans_complete_i = 1'b0;
    logic           clear_error_i = 1'b0;
    logic [1:0]     owner_o;

    int  n_checks = 0;
    int  n_fail = 0;
    int  rr_m = 0;
    bit  err_m = 1'b0;
    bit  timeout_now = 1'b0;
    bit  rand_clear = 1'b0;

    mempool_dma_arbiter #(
        .NumRequesters (N),
        .AddrWidth     (A),
        .LenWidth      (L),
        .TimeoutCycles (T)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .req_src_i            (req_src_i),
        .req_dst_i            (req_dst_i),
        .req_num_bytes_i      (req_num_bytes_i),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_done_o           (req_done_o),
        .dma_src_o            (dma_src_o),
        .dma_dst_o            (dma_dst_o),
        .dma_num_bytes_o      (dma_num_bytes_o),
        .dma_valid_o          (dma_valid_o),
        .dma_ready_i          (dma_ready_i),
        .dma_trans_complete_i (dma_trans_complete_i),
        .busy_o               (busy_o),
        .owner_o              (owner_o),
        .error_o              (error_o),
        .clear_error_i        (clear_error_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic scramble();
        for (int k = 0; k < N; k++) begin
            req_src_i[k*A +: A]       = $urandom;
            req_dst_i[k*A +: A]       = $urandom;
            req_num_bytes_i[k*L +: L] = $urandom;
        end
        req_valid_i = N'($urandom);
        clear_error_i = rand_clear && ($urandom_range(0, 3) == 0);
    endtask

    // One clock edge; the sticky error model advances with it.
    task automatic cyc();
        bit nxt;
        nxt = err_m;
        if (timeout_now) nxt = 1'b1;
        else if (clear_error_i) nxt = 1'b0;
        @(posedge clk);
        #1;
        err_m = nxt;
        timeout_now = 1'b0;
        check("error", error_o, err_m);
    endtask

    task automatic txn(input logic [N-1:0] mask, input logic [A-1:0] src, input logic [A-1:0] dst,
                       input logic [L-1:0] len, input int rdly, input int cdly);
        int w;
        scramble();
        w = pick(mask);
        req_valid_i = mask;
        req_src_i[w*A +: A] = src;
        req_dst_i[w*A +: A] = dst;
        req_num_bytes_i[w*L +: L] = len;
        dma_ready_i = 1'b0;
        dma_trans_complete_i = $urandom_range(0, 1);
        #1;
        check("grant", req_ready_o, 64'(1) << w);
        check("idle_busy", busy_o, 0);
        check("idle_valid", dma_valid_o, 0);
        cyc();
        rr_m = (w + 1) % N;
        check("owner", owner_o, w);
        check("busy", busy_o, 1);
        if (len == 0) begin
            scramble();
            req_valid_i = '0;
            #1;
            check("zl_valid", dma_valid_o, 0);
            check("zl_done", req_done_o, 64'(1) << w);
            cyc();
            check("zl_done_end", req_done_o, 0);
            check("zl_busy_end", busy_o, 0);
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            scramble();
            dma_ready_i = (i == rdly);
            dma_trans_complete_i = $urandom_range(0, 1);
            #1;
            check("issue_valid", dma_valid_o, 1);
            check("issue_src", dma_src_o, src);
            check("issue_dst", dma_dst_o, dst);
            check("issue_len", dma_num_bytes_o, len);
            check("issue_ready", req_ready_o, 0);
            check("issue_done", req_done_o, 0);
            cyc();
        end
        for (int j = 0; j <= T; j++) begin
            scramble();
            dma_ready_i = $urandom_range(0, 1);
            dma_trans_complete_i = (j == cdly);
            timeout_now = (j == T) && (cdly != j);
            #1;
            check("wait_valid", dma_valid_o, 0);
            check("wait_done", req_done_o, 0);
            check("wait_busy", busy_o, 1);
            cyc();
            if (j == cdly || j == T) break;
        end
        scramble();
        req_valid_i = '0;
        dma_trans_complete_i = $urandom_range(0, 1);
        #1;
        check("done", req_done_o, 64'(1) << w);
        check("done_owner", owner_o, w);
        check("done_busy", busy_o, 1);
        check("done_ready", req_ready_o, 0);
        cyc();
        check("done_end", req_done_o, 0);
        check("busy_end", busy_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready_o, 0);
        check({tag, "_done"}, req_done_o, 0);
        check({tag, "_valid"}, dma_valid_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_err"}, error_o, 0);
        check({tag, "_owner"}, owner_o, 0);
        check({tag, "_src"}, dma_src_o, 0);
        check({tag, "_dst"}, dma_dst_o, 0);
        check({tag, "_len"}, dma_num_bytes_o, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_all_zero("reset");

        // Round-robin with every requester valid and immediate completion.
        for (int i = 0; i < 6; i++) txn(4'hF, 32'($urandom), 32'($urandom), 32'd4 + i, 0, 0);
        // Single transfer from requester 1.
        txn(4'b0010, 32'h100, 32'h8000_0000, 32'd64, 0, 10);
        // Zero length from requester 2, then the pointer must favour requester 3.
        txn(4'b0100, 32'h40, 32'h80, 32'd0, 0, 0);
        txn(4'hF, 32'h44, 32'h88, 32'd8, 0, 1);
        // Backpressure for seven cycles.
        txn(4'b1001, 32'hDEAD_0000, 32'hBEEF_0000, 32'd128, 7, 3);
        // Watchdog expiry, then clear, then completion racing the timeout.
        txn(4'b0001, 32'h1, 32'h2, 32'd16, 0, T + 3);
        check("err_sticky", error_o, 1);
        clear_error_i = 1'b1;
        cyc();
        clear_error_i = 1'b0;
        cyc();
        txn(4'b0100, 32'h3, 32'h4, 32'd16, 1, T);

        // Reset during WAIT followed by a stray completion.
        scramble();
        clear_error_i = 1'b0;
        req_valid_i = 4'b0010;
        req_num_bytes_i[1*L +: L] = 32'd32;
        dma_trans_complete_i = 1'b0;
        dma_ready_i = 1'b1;
        cyc();
        cyc();
        dma_ready_i = 1'b0;
        req_valid_i = '0;
        cyc();
        check("pre_reset_busy", busy_o, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        rr_m = 0;
        err_m = 1'b0;
        check_all_zero("midreset");
        dma_trans_complete_i = 1'b1;
        cyc();
        dma_trans_complete_i = 1'b0;
        check("stray_done", req_done_o, 0);
        check("stray_busy", busy_o, 0);
        cyc();
        check("stray_done2", req_done_o, 0);

        rand_clear = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] m;
            logic [L-1:0] len;
            m = N'($urandom_range(1, (1 << N) - 1));
            len = ($urandom_range(0, 3) == 0) ? '0 : L'($urandom_range(1, 4096));
            txn(m, 32'($urandom), 32'($urandom), len, $urandom_range(0, 4), $urandom_range(0, T + 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
